fetch_stage: RTL and testbench

//  Fetch stage: PC register, next-PC select, boot vector load, interrupt latch, and F/D pipeline register.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_stage_if.sv | 35 +++
 rtl/fetch_stage_fd_buffer.sv | 41 ++++
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Constants shared by the fetch stage and the decode control unit.
package fetch_stage_pkg;

   localparam logic [1:0] JSEL_SEQ = 2'b00;
   localparam logic [1:0] JSEL_JMP = 2'b01;
   localparam logic [1:0] JSEL_INT = 2'b10;
   localparam logic [1:0] JSEL_RET = 2'b11;

   localparam logic [15:0] NOP_INST = 16'h0000;

   typedef enum logic [1:0] {
      BOOT_HI = 2'b00,
      BOOT_LO = 2'b01,
      RUN     = 2'b10
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: decode CU controls, instruction memory port and F/D register outputs.
interface fetch_stage_if #(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INST_W = 16
);
   logic              pc_enable;
   logic              f_d_buffer_enable;
   logic              flush;
   logic [1:0]        jump_sel;
   logic [PC_W-1:0]   jump_target;
   logic [PC_W-1:0]   ret_target;
   logic              br_taken;
   logic [PC_W-1:0]   br_target;
   logic              irq_in;
   logic [PC_W-1:0]   imem_addr;
   logic [INST_W-1:0] imem_rdata;
   logic [INST_W-1:0] fd_inst;
   logic [PC_W-1:0]   fd_pc_next;
   logic              fd_valid;
   logic              interrupt;
   logic              boot_done;

   modport master (
      input  pc_enable, f_d_buffer_enable, flush, jump_sel, jump_target, ret_target,
             br_taken, br_target, irq_in, imem_rdata,
      output imem_addr, fd_inst, fd_pc_next, fd_valid, interrupt, boot_done
   );

   modport slave (
      output pc_enable, f_d_buffer_enable, flush, jump_sel, jump_target, ret_target,
             br_taken, br_target, irq_in, imem_rdata,
      input  imem_addr, fd_inst, fd_pc_next, fd_valid, interrupt, boot_done
   );

endinterface

// File: rtl/fetch_stage_fd_buffer.sv
// F/D pipeline register with load enable and NOP insertion on kill.
module fd_buffer
   import fetch_stage_pkg::*;
#(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INST_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              kill,
   input  logic              load,
   input  logic [INST_W-1:0] inst_in,
   input  logic [PC_W-1:0]   pc_next_in,
   output logic [INST_W-1:0] inst,
   output logic [PC_W-1:0]   pc_next,
   output logic              valid
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst    <= INST_W'(NOP_INST);
         pc_next <= '0;
         valid   <= 1'b0;
      end else if (!run) begin
         inst    <= INST_W'(NOP_INST);
         pc_next <= '0;
         valid   <= 1'b0;
      end else if (kill) begin
         // kill overrides a stalled register; the return address still advances
         inst    <= INST_W'(NOP_INST);
         pc_next <= pc_next_in;
         valid   <= 1'b0;
      end else if (load) begin
         inst    <= inst_in;
         pc_next <= pc_next_in;
         valid   <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: boot vector load, PC / next-PC select, interrupt latch and F/D register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned     PC_W      = 32,
   parameter int unsigned     INST_W    = 16,
   parameter logic [PC_W-1:0] RESET_VEC = '0,
   parameter logic [PC_W-1:0] INT_VEC   = PC_W'(2)
) (
   input logic           clk,
   input logic           rst_n,
   fetch_stage_if.master bus
);

   fetch_state_t    state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_plus1;
   logic            int_pending;
   logic            boot_done_r;
   logic            run;

   assign run      = (state == RUN);
   assign pc_plus1 = pc + 1'b1;

   always_comb begin
      bus.imem_addr = pc;
      case (state)
         BOOT_HI: bus.imem_addr = RESET_VEC;
         BOOT_LO: bus.imem_addr = RESET_VEC + 1'b1;
         default: bus.imem_addr = pc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT_HI;
         pc          <= '0;
         int_pending <= 1'b0;
         boot_done_r <= 1'b0;
      end else begin
         case (state)
            BOOT_HI: begin
               pc[PC_W-1 -: INST_W] <= bus.imem_rdata;
               state                <= BOOT_LO;
            end
            BOOT_LO: begin
               pc[INST_W-1:0] <= bus.imem_rdata;
               state          <= RUN;
               boot_done_r    <= 1'b1;
            end
            RUN: begin
               if (bus.br_taken)
                  pc <= bus.br_target;
               else if (bus.pc_enable) begin
                  case (bus.jump_sel)
                     JSEL_SEQ: pc <= pc_plus1;
                     JSEL_JMP: pc <= bus.jump_target;
                     JSEL_INT: pc <= INT_VEC;
                     JSEL_RET: pc <= bus.ret_target;
                  endcase
               end
               // a new request on the acknowledge edge keeps the latch set
               if (bus.irq_in)
                  int_pending <= 1'b1;
               else if (bus.pc_enable && bus.jump_sel == JSEL_INT)
                  int_pending <= 1'b0;
            end
            default: state <= BOOT_HI;
         endcase
      end
   end

   fd_buffer #(
      .PC_W   (PC_W),
      .INST_W (INST_W)
   ) u_fd_buffer (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .kill       (bus.br_taken | bus.flush),
      .load       (bus.f_d_buffer_enable),
      .inst_in    (bus.imem_rdata),
      .pc_next_in (pc_plus1),
      .inst       (bus.fd_inst),
      .pc_next    (bus.fd_pc_next),
      .valid      (bus.fd_valid)
   );

   assign bus.interrupt = int_pending & bus.fd_valid;
   assign bus.boot_done = boot_done_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized run against a reference model.
module tb_fetch_stage;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic [15:0] mem [0:1023];

   // reference model state
   int          m_phase;
   logic [31:0] m_pc;
   logic [31:0] m_pcn;
   logic [15:0] m_inst;
   logic        m_valid;
   logic        m_pend;

   fetch_stage_if #(.PC_W(32), .INST_W(16)) bus ();

   fetch_stage #(
      .PC_W      (32),
      .INST_W    (16),
      .RESET_VEC (32'h0),
      .INT_VEC   (32'h2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.imem_rdata = mem[bus.imem_addr[9:0]];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] model_addr();
      if (m_phase == 0) return 32'h0;
      if (m_phase == 1) return 32'h1;
      return m_pc;
   endfunction

   task automatic set_idle();
      bus.pc_enable         = 1'b1;
      bus.f_d_buffer_enable = 1'b1;
      bus.flush             = 1'b0;
      bus.jump_sel          = 2'b00;
      bus.jump_target       = '0;
      bus.ret_target        = '0;
      bus.br_taken          = 1'b0;
      bus.br_target         = '0;
      bus.irq_in            = 1'b0;
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_pc    = '0;
      m_pcn   = '0;
      m_inst  = '0;
      m_valid = 1'b0;
      m_pend  = 1'b0;
   endtask

   // Apply the fetch rules to the model for the coming edge, then advance one clock.
   task automatic tick();
      logic [31:0] a;
      logic [15:0] rd;
      logic [31:0] p1;
      a  = model_addr();
      rd = mem[a[9:0]];
      if (m_phase == 0) begin
         m_pc    = {rd, m_pc[15:0]};
         m_phase = 1;
      end else if (m_phase == 1) begin
         m_pc    = {m_pc[31:16], rd};
         m_phase = 2;
      end else begin
         p1 = m_pc + 32'd1;
         if (bus.br_taken || bus.flush) begin
            m_inst = 16'h0; m_valid = 1'b0; m_pcn = p1;
         end else if (bus.f_d_buffer_enable) begin
            m_inst = rd; m_valid = 1'b1; m_pcn = p1;
         end
         if (bus.irq_in) m_pend = 1'b1;
         else if (bus.pc_enable && bus.jump_sel == 2'b10) m_pend = 1'b0;
         if (bus.br_taken) m_pc = bus.br_target;
         else if (bus.pc_enable) begin
            case (bus.jump_sel)
               2'b00: m_pc = p1;
               2'b01: m_pc = bus.jump_target;
               2'b10: m_pc = 32'h2;
               default: m_pc = bus.ret_target;
            endcase
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_idle();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_idle();
      model_reset();
      #2;
      checks++;
      if (bus.fd_inst !== 16'h0 || bus.fd_pc_next !== 32'h0 || bus.fd_valid !== 1'b0 ||
          bus.interrupt !== 1'b0 || bus.boot_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got inst=%h pcn=%h v=%b int=%b bd=%b, want all zero",
                  bus.fd_inst, bus.fd_pc_next, bus.fd_valid, bus.interrupt, bus.boot_done);
      end
      checks++;
      if (bus.imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_addr: got %h want 00000000", bus.imem_addr);
      end
   endtask

   task automatic test_boot();
      mem[0] = 16'h0000;
      mem[1] = 16'h0010;
      do_reset();
      checks++;
      if (bus.imem_addr !== 32'h0) begin
         errors++; $display("FAIL boot_hi_addr: got %h want 00000000", bus.imem_addr);
      end
      tick();
      checks++;
      if (bus.imem_addr !== 32'h1 || bus.boot_done !== 1'b0) begin
         errors++; $display("FAIL boot_lo: got addr=%h bd=%b want 00000001/0", bus.imem_addr, bus.boot_done);
      end
      tick();
      checks++;
      if (bus.imem_addr !== 32'h10 || bus.boot_done !== 1'b1 || bus.fd_valid !== 1'b0) begin
         errors++;
         $display("FAIL boot_run: got addr=%h bd=%b v=%b want 00000010/1/0",
                  bus.imem_addr, bus.boot_done, bus.fd_valid);
      end
      tick();
      checks++;
      if (bus.fd_inst !== mem[16] || bus.fd_pc_next !== 32'h11 || bus.fd_valid !== 1'b1) begin
         errors++;
         $display("FAIL first_fetch: got inst=%h pcn=%h v=%b want %h/00000011/1",
                  bus.fd_inst, bus.fd_pc_next, bus.fd_valid, mem[16]);
      end
   endtask

   task automatic test_hold();
      logic [31:0] a;
      logic [15:0] inst;
      tick(); tick();
      a    = bus.imem_addr;
      inst = bus.fd_inst;
      bus.pc_enable = 1'b0;
      bus.f_d_buffer_enable = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (bus.imem_addr !== a || bus.fd_inst !== inst) begin
            errors++;
            $display("FAIL hold: got addr=%h inst=%h want %h/%h", bus.imem_addr, bus.fd_inst, a, inst);
         end
      end
      set_idle();
      tick();
      checks++;
      if (bus.fd_inst !== mem[a[9:0]] || bus.imem_addr !== a + 32'd1) begin
         errors++;
         $display("FAIL resume: got inst=%h addr=%h want %h/%h",
                  bus.fd_inst, bus.imem_addr, mem[a[9:0]], a + 32'd1);
      end
   endtask

   task automatic test_jump();
      bus.jump_sel    = 2'b01;
      bus.jump_target = 32'h40;
      bus.flush       = 1'b1;
      tick();
      checks++;
      if (bus.imem_addr !== 32'h40 || bus.fd_inst !== 16'h0 || bus.fd_valid !== 1'b0) begin
         errors++;
         $display("FAIL jump: got addr=%h inst=%h v=%b want 00000040/0000/0",
                  bus.imem_addr, bus.fd_inst, bus.fd_valid);
      end
      set_idle();
      tick();
      checks++;
      if (bus.fd_inst !== mem[16'h40] || bus.fd_valid !== 1'b1 || bus.fd_pc_next !== 32'h41) begin
         errors++;
         $display("FAIL jump_target_fetch: got inst=%h v=%b pcn=%h want %h/1/00000041",
                  bus.fd_inst, bus.fd_valid, bus.fd_pc_next, mem[16'h40]);
      end
   endtask

   task automatic test_branch();
      logic [31:0] a;
      a = bus.imem_addr;
      bus.br_taken          = 1'b1;
      bus.br_target         = 32'h80;
      bus.pc_enable         = 1'b0;
      bus.f_d_buffer_enable = 1'b0;
      bus.jump_sel          = 2'b11;
      bus.ret_target        = 32'h200;
      tick();
      checks++;
      if (bus.imem_addr !== 32'h80 || bus.fd_inst !== 16'h0 || bus.fd_valid !== 1'b0 ||
          bus.fd_pc_next !== a + 32'd1) begin
         errors++;
         $display("FAIL branch: got addr=%h inst=%h v=%b pcn=%h want 00000080/0000/0/%h",
                  bus.imem_addr, bus.fd_inst, bus.fd_valid, bus.fd_pc_next, a + 32'd1);
      end
      set_idle();
      tick();
   endtask

   task automatic test_irq();
      bus.irq_in = 1'b1;
      tick();
      bus.irq_in = 1'b0;
      checks++;
      if (bus.interrupt !== 1'b1) begin
         errors++; $display("FAIL irq_set: got %b want 1", bus.interrupt);
      end
      tick();
      checks++;
      if (bus.interrupt !== 1'b1) begin
         errors++; $display("FAIL irq_hold: got %b want 1", bus.interrupt);
      end
      bus.jump_sel = 2'b10;
      tick();
      checks++;
      if (bus.imem_addr !== 32'h2 || bus.interrupt !== 1'b0) begin
         errors++;
         $display("FAIL irq_take: got addr=%h int=%b want 00000002/0", bus.imem_addr, bus.interrupt);
      end
      set_idle();
      bus.irq_in = 1'b1;
      tick();
      bus.jump_sel = 2'b10;
      tick();
      bus.irq_in = 1'b0;
      bus.jump_sel = 2'b00;
      checks++;
      if (bus.interrupt !== 1'b1) begin
         errors++; $display("FAIL irq_set_wins: got %b want 1", bus.interrupt);
      end
      tick();
   endtask

   task automatic test_async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.fd_inst !== 16'h0 || bus.fd_pc_next !== 32'h0 || bus.fd_valid !== 1'b0 ||
          bus.interrupt !== 1'b0 || bus.boot_done !== 1'b0 || bus.imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL async_reset: got inst=%h pcn=%h v=%b int=%b bd=%b addr=%h want all zero",
                  bus.fd_inst, bus.fd_pc_next, bus.fd_valid, bus.interrupt, bus.boot_done, bus.imem_addr);
      end
      do_reset();
      tick();
      checks++;
      if (bus.imem_addr !== 32'h1 || bus.boot_done !== 1'b0) begin
         errors++; $display("FAIL reboot_lo: got addr=%h bd=%b want 00000001/0", bus.imem_addr, bus.boot_done);
      end
      tick();
      tick();
      checks++;
      if (bus.interrupt !== 1'b0 || bus.fd_valid !== 1'b1 || bus.boot_done !== 1'b1) begin
         errors++;
         $display("FAIL reboot_run: got int=%b v=%b bd=%b want 0/1/1", bus.interrupt, bus.fd_valid, bus.boot_done);
      end
   endtask

   task automatic test_wrap();
      mem[0] = 16'hFFFF;
      mem[1] = 16'hFFFF;
      do_reset();
      tick(); tick();
      checks++;
      if (bus.imem_addr !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL wrap_boot: got %h want ffffffff", bus.imem_addr);
      end
      tick();
      checks++;
      if (bus.imem_addr !== 32'h0 || bus.fd_pc_next !== 32'h0 || bus.fd_inst !== mem[1023]) begin
         errors++;
         $display("FAIL wrap: got addr=%h pcn=%h inst=%h want 00000000/00000000/%h",
                  bus.imem_addr, bus.fd_pc_next, bus.fd_inst, mem[1023]);
      end
   endtask

   task automatic test_random();
      for (int i = 2; i < 1024; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h0000;
      mem[1] = 16'($urandom_range(0, 1023));
      do_reset();
      for (int c = 0; c < 400; c++) begin
         bus.pc_enable         = ($urandom_range(0, 9) < 8);
         bus.f_d_buffer_enable = ($urandom_range(0, 9) < 8);
         bus.flush             = ($urandom_range(0, 9) == 0);
         bus.jump_sel          = 2'($urandom_range(0, 3));
         bus.jump_target       = 32'($urandom_range(0, 1023));
         bus.ret_target        = 32'($urandom_range(0, 1023));
         bus.br_taken          = ($urandom_range(0, 9) == 0);
         bus.br_target         = 32'($urandom_range(0, 1023));
         bus.irq_in            = ($urandom_range(0, 19) == 0);
         tick();
         checks++;
         if (bus.imem_addr !== model_addr() || bus.fd_inst !== m_inst || bus.fd_pc_next !== m_pcn ||
             bus.fd_valid !== m_valid || bus.interrupt !== (m_pend & m_valid) ||
             bus.boot_done !== (m_phase == 2)) begin
            errors++;
            $display("FAIL random cycle %0d: got addr=%h inst=%h pcn=%h v=%b int=%b bd=%b want %h/%h/%h/%b/%b/%b",
                     c, bus.imem_addr, bus.fd_inst, bus.fd_pc_next, bus.fd_valid, bus.interrupt,
                     bus.boot_done, model_addr(), m_inst, m_pcn, m_valid, m_pend & m_valid, m_phase == 2);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
      test_reset();
      test_boot();
      test_hold();
      test_jump();
      test_branch();
      test_irq();
      bus.irq_in = 1'b1;
      tick();
      set_idle();
      test_async_reset();
      test_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
